// File: rtl/alu_exec_stage.sv
// alu_exec_stage: two-beat (low half, then high half with carry) execute-stage ALU with valid/ready handshakes
module alu_exec_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal_op
);
    localparam int HALF = XLEN / 2;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;

    typedef enum logic [1:0] {IDLE, LOW, HIGH, HOLD} state_t;

    state_t          r_state;
    logic [3:0]      r_op;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [HALF-1:0] r_lo;
    logic            r_carry;
    logic [XLEN-1:0] r_result;
    logic            r_zero;
    logic            r_illegal;

    logic            w_accept;
    logic            w_sub;
    logic            w_legal;
    logic [XLEN-1:0] w_b_eff;
    logic [HALF:0]   w_lo_sum;
    logic [HALF-1:0] w_hi_sum;
    logic [HALF-1:0] w_lo_res;
    logic [HALF-1:0] w_hi_res;
    logic [XLEN-1:0] w_full;

    assign in_ready   = (r_state == IDLE) || (r_state == HOLD && out_ready);
    assign w_accept   = in_valid && in_ready;
    assign out_valid  = r_state == HOLD;
    assign result     = r_result;
    assign zero       = r_zero;
    assign illegal_op = r_illegal;

    // Half-width datapath: subtraction is a + ~b + 1, the +1 injected as carry-in of the low beat
    always_comb begin
        w_sub    = r_op == OP_SUB;
        w_legal  = (r_op == OP_AND) || (r_op == OP_OR) || (r_op == OP_ADD) || w_sub;
        w_b_eff  = w_sub ? ~r_b : r_b;
        w_lo_sum = {1'b0, r_a[HALF-1:0]} + {1'b0, w_b_eff[HALF-1:0]} + {{HALF{1'b0}}, w_sub};
        w_hi_sum = r_a[XLEN-1:HALF] + w_b_eff[XLEN-1:HALF] + {{(HALF-1){1'b0}}, r_carry};
        w_lo_res = (r_op == OP_AND) ? (r_a[HALF-1:0] & r_b[HALF-1:0]) :
                   (r_op == OP_OR)  ? (r_a[HALF-1:0] | r_b[HALF-1:0]) : w_lo_sum[HALF-1:0];
        w_hi_res = (r_op == OP_AND) ? (r_a[XLEN-1:HALF] & r_b[XLEN-1:HALF]) :
                   (r_op == OP_OR)  ? (r_a[XLEN-1:HALF] | r_b[XLEN-1:HALF]) : w_hi_sum;
        w_full   = w_legal ? {w_hi_res, r_lo} : '0;
    end

    // Control FSM: accept -> LOW -> HIGH -> HOLD, results registered on HIGH exit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_lo      <= '0;
            r_carry   <= 1'b0;
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
        end else if (w_accept) begin
            r_op    <= alu_op;
            r_a     <= operand_a;
            r_b     <= operand_b;
            r_state <= LOW;
        end else begin
            case (r_state)
                LOW: begin
                    r_lo    <= w_lo_res;
                    r_carry <= w_lo_sum[HALF];
                    r_state <= HIGH;
                end
                HIGH: begin
                    r_result  <= w_full;
                    r_zero    <= w_full == '0;
                    r_illegal <= !w_legal;
                    r_state   <= HOLD;
                end
                HOLD: if (out_ready) r_state <= IDLE;
                default: ;
            endcase
        end
    end
endmodule
